// File: rtl/lbdr_input_fifo.sv
// lbdr_input_fifo
// Input-port flit buffer feeding the LBDR routing stage. Write side checks
// packet framing (HEADER ... PAYLOAD* ... TAIL), read side is first-word-
// fall-through. One credit pulse is returned upstream per consumed flit.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | between packets, only a HEADER flit is legal
// IN_PKT | header accepted, PAYLOAD or TAIL legal, TAIL closes packet

module lbdr_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [2:0]            flit_id,
    output logic [3:0]            dst_addr,
    output logic                  empty,
    output logic                  full,
    output logic [PTR_W:0]        count,
    output logic                  credit_out,
    output logic                  err_proto,
    output logic                  err_ovf
);

    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    logic [2:0] din_id;
    logic       frame_ok;
    logic       wr_acc;
    logic       rd_acc;
    logic       proto_bad;
    logic       ovf_hit;

    assign din_id = din[DATA_WIDTH-1 -: 3];

    // Status flags come straight from the registered occupancy.
    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    // Framing check and next state. Only a flit that actually reaches the
    // framer (not blocked by full) may advance the FSM or raise err_proto.
    always_comb begin
        state_next = state;
        frame_ok   = 1'b0;
        if (wr_en && !full) begin
            case (state)
                IDLE: begin
                    if (din_id == HEADER) begin
                        frame_ok   = 1'b1;
                        state_next = IN_PKT;
                    end
                end
                IN_PKT: begin
                    if (din_id == PAYLOAD) begin
                        frame_ok = 1'b1;
                    end else if (din_id == TAIL) begin
                        frame_ok   = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign wr_acc    = wr_en && !full && frame_ok;
    assign rd_acc    = rd_en && !empty;
    assign proto_bad = wr_en && !full && !frame_ok;
    assign ovf_hit   = wr_en && full;

    // Framing state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flit storage; deliberately not reset, dout masking hides stale data.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy. Power-of-two depth makes the wrap implicit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered one-cycle pulses: credit back upstream and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_out <= 1'b0;
            err_proto  <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            credit_out <= rd_acc;
            err_proto  <= proto_bad;
            err_ovf    <= ovf_hit;
        end
    end

    // FWFT head view for the routing stage.
    always_comb begin
        dout = '0;
        if (!empty) begin
            dout = mem[rd_ptr];
        end
    end

    assign flit_id  = dout[DATA_WIDTH-1 -: 3];
    assign dst_addr = dout[3:0];

endmodule

// File: tb/tb_lbdr_input_fifo.sv
// Directed bench for lbdr_input_fifo.
module tb_lbdr_input_fifo;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [31:0] din;
    logic        rd_en;
    logic [31:0] dout;
    logic [2:0]  flit_id;
    logic [3:0]  dst_addr;
    logic        empty;
    logic        full;
    logic [2:0]  count;
    logic        credit_out;
    logic        err_proto;
    logic        err_ovf;

    int checks   = 0;
    int failures = 0;

    lbdr_input_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .din        (din),
        .rd_en      (rd_en),
        .dout       (dout),
        .flit_id    (flit_id),
        .dst_addr   (dst_addr),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .credit_out (credit_out),
        .err_proto  (err_proto),
        .err_ovf    (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, settle 1 time unit.
    task automatic cyc(input logic w, input logic [31:0] d, input logic r);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    logic [31:0] fill [4];
    logic [31:0] strm [10];

    initial begin
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_dout", dout, 0);
        chk("rst_credit", 32'(credit_out), 0);
        chk("rst_errp", 32'(err_proto), 0);
        chk("rst_erro", 32'(err_ovf), 0);

        // Three-flit packet, no reads.
        cyc(1'b1, 32'h2000_000A, 1'b0);
        chk("w1_dout", dout, 32'h2000_000A);
        chk("w1_empty", 32'(empty), 0);
        cyc(1'b1, 32'h4000_1234, 1'b0);
        cyc(1'b1, 32'h8000_5678, 1'b0);
        chk("pkt3_count", 32'(count), 3);
        chk("pkt3_empty", 32'(empty), 0);
        chk("pkt3_full", 32'(full), 0);
        chk("pkt3_id", 32'(flit_id), 1);
        chk("pkt3_dst", 32'(dst_addr), 32'hA);

        cyc(1'b0, 0, 1'b1);
        chk("d1_credit", 32'(credit_out), 1);
        chk("d1_dout", dout, 32'h4000_1234);
        cyc(1'b0, 0, 1'b1);
        chk("d2_dout", dout, 32'h8000_5678);
        cyc(1'b0, 0, 1'b1);
        chk("d3_empty", 32'(empty), 1);
        chk("d3_dout", dout, 0);
        cyc(1'b0, 0, 1'b0);
        chk("d4_credit_end", 32'(credit_out), 0);

        // Read while empty is ignored.
        cyc(1'b0, 0, 1'b1);
        chk("rde_credit", 32'(credit_out), 0);
        chk("rde_count", 32'(count), 0);

        // Fill to DEPTH, then overflow.
        fill[0] = 32'h2000_0001;
        fill[1] = 32'h4000_0011;
        fill[2] = 32'h4000_0022;
        fill[3] = 32'h8000_0033;
        for (int i = 0; i < 4; i++) cyc(1'b1, fill[i], 1'b0);
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 4);
        chk("fill_erro", 32'(err_ovf), 0);
        cyc(1'b1, 32'h2000_0005, 1'b0);
        chk("ovf_pulse", 32'(err_ovf), 1);
        chk("ovf_errp", 32'(err_proto), 0);
        chk("ovf_count", 32'(count), 4);
        cyc(1'b0, 0, 1'b0);
        chk("ovf_clear", 32'(err_ovf), 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_dout", i), dout, fill[i]);
            cyc(1'b0, 0, 1'b1);
            chk($sformatf("drain%0d_credit", i), 32'(credit_out), 1);
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_dout", dout, 0);

        // PAYLOAD while idle.
        cyc(1'b1, 32'h4000_0000, 1'b0);
        chk("idlep_errp", 32'(err_proto), 1);
        chk("idlep_count", 32'(count), 0);
        cyc(1'b0, 0, 1'b0);
        chk("idlep_clear", 32'(err_proto), 0);

        // Second HEADER inside a packet.
        cyc(1'b1, 32'h2000_0003, 1'b0);
        chk("hh_first_errp", 32'(err_proto), 0);
        cyc(1'b1, 32'h2000_0004, 1'b0);
        chk("hh_errp", 32'(err_proto), 1);
        chk("hh_count", 32'(count), 1);
        cyc(1'b1, 32'h8000_0007, 1'b0);
        chk("hh_tail_errp", 32'(err_proto), 0);
        chk("hh_tail_count", 32'(count), 2);
        chk("hh_head", dout, 32'h2000_0003);
        cyc(1'b0, 0, 1'b1);
        chk("hh_second", dout, 32'h8000_0007);
        cyc(1'b0, 0, 1'b1);
        chk("hh_empty", 32'(empty), 1);

        // Streaming: 10 flits, read starts one cycle after first write.
        strm[0] = 32'h2000_0009;
        for (int k = 1; k < 9; k++) strm[k] = 32'h4000_0000 | 32'(k);
        strm[9] = 32'h8000_0009;
        cyc(1'b1, strm[0], 1'b0);
        chk("st0_count", 32'(count), 1);
        for (int k = 1; k < 10; k++) begin
            chk($sformatf("st%0d_dout", k), dout, strm[k-1]);
            cyc(1'b1, strm[k], 1'b1);
            chk($sformatf("st%0d_count", k), 32'(count), 1);
            chk($sformatf("st%0d_credit", k), 32'(credit_out), 1);
            chk($sformatf("st%0d_errp", k), 32'(err_proto), 0);
        end
        chk("st_last_dout", dout, strm[9]);
        cyc(1'b0, 0, 1'b1);
        chk("st_end_credit", 32'(credit_out), 1);
        chk("st_end_empty", 32'(empty), 1);

        // Reset mid-packet with concurrent write and read.
        cyc(1'b1, 32'h2000_000F, 1'b0);
        cyc(1'b1, 32'h4000_00AA, 1'b0);
        cyc(1'b1, 32'h4000_00BB, 1'b0);
        chk("prer_count", 32'(count), 3);
        rst = 1'b1;
        cyc(1'b1, 32'h8000_00CC, 1'b1);
        rst = 1'b0;
        chk("mrst_count", 32'(count), 0);
        chk("mrst_empty", 32'(empty), 1);
        chk("mrst_credit", 32'(credit_out), 0);
        chk("mrst_dout", dout, 0);
        cyc(1'b1, 32'h4000_00DD, 1'b0);
        chk("mrst_errp", 32'(err_proto), 1);
        chk("mrst_after_count", 32'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
